ls_unit_wb2: RTL and testbench
==============================

Name: ls_unit_wb2

Overview:
- Second-generation load/store unit: one instruction-fetch channel and one data load/store channel, each a Wishbone classic master.
- Adds byte/half/word data accesses with lane steering and sign/zero extension.
- Adds a per-channel parametrised no-response timeout, precise fault cause codes and re-armable fault handling (no dead-lock state).
- Sits between the core pipeline (fetch and memory stages) and the instruction/data buses.

Parameters:
- ADDR_W, 32, address width of both buses and request addresses.
- TIMEOUT, 1024, cycles a bus cycle may stay un-acked before a timeout fault (min 2).
- CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- if_req  input  1  fetch request, sampled only in IDLE.
- if_pc  input  ADDR_W  fetch address.
- if_instr  output  32  fetched instruction, valid with if_valid.
- if_valid  output  1  one-cycle completion pulse.
- if_fault  output  1  one-cycle fault pulse.
- if_cause  output  2  fault cause, valid with if_fault.
- if_stall  output  1  fetch channel busy.
- iwb_addr_o  output  ADDR_W  instruction bus address.
- iwb_cyc_o  output  1  instruction bus cycle.
- iwb_stb_o  output  1  instruction bus strobe.
- iwb_dat_i  input  32  instruction read data.
- iwb_ack_i  input  1  instruction bus acknowledge.
- iwb_err_i  input  1  instruction bus error.
- ls_req  input  1  data request, sampled only in IDLE.
- ls_we  input  1  1 = store, 0 = load.
- ls_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- ls_unsigned  input  1  zero-extend loads when 1.
- ls_addr  input  ADDR_W  data byte address.
- ls_wdata  input  32  store data, right-aligned.
- ls_rdata  output  32  extended load data, valid with ls_done.
- ls_done  output  1  one-cycle completion pulse.
- ls_fault  output  1  one-cycle fault pulse.
- ls_cause  output  2  fault cause, valid with ls_fault.
- ls_stall  output  1  data channel busy.
- dwb_addr_o  output  ADDR_W  data bus address, word-aligned ([1:0]=0).
- dwb_dat_o  output  32  lane-steered store data.
- dwb_sel_o  output  4  byte lane selects.
- dwb_we_o  output  1  data bus write enable.
- dwb_cyc_o  output  1  data bus cycle.
- dwb_stb_o  output  1  data bus strobe.
- dwb_dat_i  input  32  data bus read data.
- dwb_ack_i  input  1  data bus acknowledge.
- dwb_err_i  input  1  data bus error.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, both FSMs IDLE, timeout counters 0. Reset asserted mid-cycle drops cyc/stb immediately, with no completion or fault pulse.
- Channel FSM, identical for both channels: IDLE, BUS, RESP.
- IDLE: on req at edge N:
  - Misaligned or illegal request: fault pulses in cycle N+1 with cause 01, no bus cycle, FSM stays IDLE. Misaligned means fetch with pc[1:0]!=0, half with addr[0]!=0, word with addr[1:0]!=0, or ls_size=11.
  - Legal request: register address/size/data, go to BUS. cyc and stb are high from cycle N+1.
- BUS: cyc and stb held high. The counter increments each cycle without ack or err.
  - ack at edge K: cyc/stb drop and data is captured; valid/done pulses high in cycle K+1; FSM goes to RESP.
  - err at edge K: same timing, fault pulses with cause 10.
  - ack and err in the same cycle: err wins.
  - Counter reaches TIMEOUT-1 without ack/err: cyc/stb drop, fault pulses with cause 11.
- RESP: one cycle, then IDLE. A new req is accepted in the cycle after RESP. Minimum throughput is one access per 3 cycles for a zero-wait slave.
- stall = (state != IDLE). Requests while stalled are ignored; the requester must hold req until it sees stall low.
- Fault cause codes: 00 none, 01 misaligned/illegal, 10 bus error, 11 timeout. The unit never locks up; after any fault it returns to IDLE.
- Store lane steering:
  - byte: sel = 0001<<addr[1:0], dat_o = {4{wdata[7:0]}}.
  - half: sel = 0011<<{addr[1],1'b0}, dat_o = {2{wdata[15:0]}}.
  - word: sel = 1111, dat_o = wdata.
  - Loads use the same sel with we = 0. The fetch bus has no sel/we; its slave treats it as a full-word read.
- Load extraction: select the byte/half by the registered addr[1:0], then sign-extend, or zero-extend if ls_unsigned.
- if_instr and ls_rdata hold their last value until the next completion.
- The two channels are fully independent and may complete in the same cycle.

Decomposition:
- Package ls_unit_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W;
  - cause codes CAUSE_NONE/MISAL/BUSERR/TIMEOUT;
  - FSM state encodings.
- Sub-module wb_chan_ctrl (parameter TIMEOUT) is instantiated twice. It holds the FSM, timeout counter, cyc/stb generation and cause selection.
- Lane steering and load extension live in the top level.

Test Plan:
- Fetch pc=0x100, slave acks 2 cycles after stb -> if_valid pulses in the cycle after ack with if_instr=0x00500093; if_stall is low the following cycle.
- Load byte addr=0x203, signed, dat_i=0x80FF1234 -> sel=1000, ls_rdata=0xFFFFFF80; repeat with ls_unsigned=1 -> 0x00000080.
- Store half addr=0x302, wdata=0x0000BEEF -> sel=1100, dat_o=0xBEEFBEEF, we=1, addr_o=0x300.
- Load word addr=0x401 -> ls_fault pulses next cycle with cause 01; dwb_cyc_o never asserts.
- Fetch with no ack, TIMEOUT=8 -> iwb_cyc_o drops after 8 bus cycles, if_fault cause 11; a following legal fetch completes normally.
- ack and err together on a store -> ls_fault cause 10, no ls_done. Separately, pull rst low mid-BUS -> cyc/stb drop immediately and no pulse is emitted.

Source files
------------

// File: rtl/ls_unit_pkg.sv
// ls_unit_pkg: shared encodings for the ls_unit_wb2 load/store unit.
// Holds access sizes, fault cause codes, channel FSM states and a helper.
package ls_unit_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISAL   = 2'b01;
    localparam logic [1:0] CAUSE_BUSERR  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } chan_st_t;

    // Illegal size or an address not aligned to the access size.
    function automatic logic misal(input logic [1:0] size,
                                   input logic [1:0] lo);
        misal = (size == 2'b11)
              | ((size == SZ_H) & lo[0])
              | ((size == SZ_W) & (|lo));
    endfunction

endpackage

// File: rtl/wb_chan_ctrl.sv
// wb_chan_ctrl: one Wishbone classic master channel (FSM, timeout, cause).
// Ports: i_req/i_misal request side, i_ack/i_err bus side, o_cyc/o_stb bus,
// o_done/o_fault/o_cause result pulses, o_stall busy, o_take/o_cap strobes.
module wb_chan_ctrl
    import ls_unit_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic       i_misal,
    input  logic       i_ack,
    input  logic       i_err,
    output logic       o_cyc,
    output logic       o_stb,
    output logic       o_done,
    output logic       o_fault,
    output logic [1:0] o_cause,
    output logic       o_stall,
    output logic       o_take,
    output logic       o_cap
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    chan_st_t         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cyc;
    logic             r_done;
    logic             r_fault;
    logic [1:0]       r_cause;

    // o_take: top registers the request; o_cap: top captures read data.
    assign o_take  = (r_state == ST_IDLE) & i_req & ~i_misal;
    assign o_cap   = (r_state == ST_BUS) & i_ack & ~i_err;
    assign o_stall = (r_state != ST_IDLE);
    assign o_cyc   = r_cyc;
    assign o_stb   = r_cyc;
    assign o_done  = r_done;
    assign o_fault = r_fault;
    assign o_cause = r_cause;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cyc   <= 1'b0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_cause <= CAUSE_NONE;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_req && i_misal) begin
                        r_fault <= 1'b1;
                        r_cause <= CAUSE_MISAL;
                    end else if (i_req) begin
                        r_state <= ST_BUS;
                        r_cyc   <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_BUS: begin
                    // err has priority over a simultaneous ack
                    if (i_err) begin
                        r_cyc   <= 1'b0;
                        r_fault <= 1'b1;
                        r_cause <= CAUSE_BUSERR;
                        r_state <= ST_RESP;
                        r_cnt   <= '0;
                    end else if (i_ack) begin
                        r_cyc   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_RESP;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_cyc   <= 1'b0;
                        r_fault <= 1'b1;
                        r_cause <= CAUSE_TIMEOUT;
                        r_state <= ST_RESP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ls_unit_wb2.sv
// ls_unit_wb2: fetch + load/store unit with two Wishbone classic masters.
// Ports: if_* fetch side, iwb_* instruction bus, ls_* data side, dwb_* data bus.
module ls_unit_wb2
    import ls_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instr,
    output logic              if_valid,
    output logic              if_fault,
    output logic [1:0]        if_cause,
    output logic              if_stall,
    output logic [ADDR_W-1:0] iwb_addr_o,
    output logic              iwb_cyc_o,
    output logic              iwb_stb_o,
    input  logic [31:0]       iwb_dat_i,
    input  logic              iwb_ack_i,
    input  logic              iwb_err_i,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic              ls_unsigned,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_done,
    output logic              ls_fault,
    output logic [1:0]        ls_cause,
    output logic              ls_stall,
    output logic [ADDR_W-1:0] dwb_addr_o,
    output logic [31:0]       dwb_dat_o,
    output logic [3:0]        dwb_sel_o,
    output logic              dwb_we_o,
    output logic              dwb_cyc_o,
    output logic              dwb_stb_o,
    input  logic [31:0]       dwb_dat_i,
    input  logic              dwb_ack_i,
    input  logic              dwb_err_i
);

    logic              w_if_take, w_if_cap;
    logic              w_ls_take, w_ls_cap;
    logic [3:0]        w_sel;
    logic [31:0]       w_wd;
    logic [31:0]       w_sh;
    logic [31:0]       w_ext;
    logic [ADDR_W-1:0] r_iaddr;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_daddr;
    logic [31:0]       r_dat;
    logic [3:0]        r_sel;
    logic              r_we;
    logic [1:0]        r_size;
    logic [1:0]        r_lo;
    logic              r_uns;
    logic [31:0]       r_rdata;

    wb_chan_ctrl #(.TIMEOUT(TIMEOUT)) u_if (
        .clk     (clk),
        .rst     (rst),
        .i_req   (if_req),
        .i_misal (misal(SZ_W, if_pc[1:0])),
        .i_ack   (iwb_ack_i),
        .i_err   (iwb_err_i),
        .o_cyc   (iwb_cyc_o),
        .o_stb   (iwb_stb_o),
        .o_done  (if_valid),
        .o_fault (if_fault),
        .o_cause (if_cause),
        .o_stall (if_stall),
        .o_take  (w_if_take),
        .o_cap   (w_if_cap)
    );

    wb_chan_ctrl #(.TIMEOUT(TIMEOUT)) u_ls (
        .clk     (clk),
        .rst     (rst),
        .i_req   (ls_req),
        .i_misal (misal(ls_size, ls_addr[1:0])),
        .i_ack   (dwb_ack_i),
        .i_err   (dwb_err_i),
        .o_cyc   (dwb_cyc_o),
        .o_stb   (dwb_stb_o),
        .o_done  (ls_done),
        .o_fault (ls_fault),
        .o_cause (ls_cause),
        .o_stall (ls_stall),
        .o_take  (w_ls_take),
        .o_cap   (w_ls_cap)
    );

    // Store lane steering from the live request (registered on take).
    always_comb begin
        w_sel = 4'b1111;
        w_wd  = ls_wdata;
        unique case (ls_size)
            SZ_B: begin
                w_sel = 4'b0001 << ls_addr[1:0];
                w_wd  = {4{ls_wdata[7:0]}};
            end
            SZ_H: begin
                w_sel = 4'b0011 << {ls_addr[1], 1'b0};
                w_wd  = {2{ls_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction uses the registered low address bits.
    assign w_sh = dwb_dat_i >> {r_lo, 3'b000};

    always_comb begin
        w_ext = dwb_dat_i;
        unique case (r_size)
            SZ_B: w_ext = r_uns ? {24'h0, w_sh[7:0]}
                                : {{24{w_sh[7]}}, w_sh[7:0]};
            SZ_H: w_ext = r_uns ? {16'h0, w_sh[15:0]}
                                : {{16{w_sh[15]}}, w_sh[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_iaddr <= '0;
            r_instr <= '0;
            r_daddr <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_size  <= SZ_B;
            r_lo    <= 2'b00;
            r_uns   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_if_take)
                r_iaddr <= if_pc;
            if (w_if_cap)
                r_instr <= iwb_dat_i;
            if (w_ls_take) begin
                r_daddr <= {ls_addr[ADDR_W-1:2], 2'b00};
                r_dat   <= w_wd;
                r_sel   <= w_sel;
                r_we    <= ls_we;
                r_size  <= ls_size;
                r_lo    <= ls_addr[1:0];
                r_uns   <= ls_unsigned;
            end
            if (w_ls_cap && !r_we)
                r_rdata <= w_ext;
        end
    end

    assign iwb_addr_o = r_iaddr;
    assign if_instr   = r_instr;
    assign dwb_addr_o = r_daddr;
    assign dwb_dat_o  = r_dat;
    assign dwb_sel_o  = r_sel;
    assign dwb_we_o   = r_we;
    assign ls_rdata   = r_rdata;

endmodule

// File: tb/tb_ls_unit_wb2.sv
// tb_ls_unit_wb2: directed self-checking bench for ls_unit_wb2.
// Drives and samples on the falling clock edge.
module tb_ls_unit_wb2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid, if_fault, if_stall;
    logic [1:0]  if_cause;
    logic [31:0] iwb_addr_o;
    logic        iwb_cyc_o, iwb_stb_o;
    logic [31:0] iwb_dat_i;
    logic        iwb_ack_i, iwb_err_i;
    logic        ls_req, ls_we, ls_unsigned;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        ls_done, ls_fault, ls_stall;
    logic [1:0]  ls_cause;
    logic [31:0] dwb_addr_o, dwb_dat_o;
    logic [3:0]  dwb_sel_o;
    logic        dwb_we_o, dwb_cyc_o, dwb_stb_o;
    logic [31:0] dwb_dat_i;
    logic        dwb_ack_i, dwb_err_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ls_unit_wb2 #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_pc(if_pc), .if_instr(if_instr),
        .if_valid(if_valid), .if_fault(if_fault), .if_cause(if_cause),
        .if_stall(if_stall), .iwb_addr_o(iwb_addr_o),
        .iwb_cyc_o(iwb_cyc_o), .iwb_stb_o(iwb_stb_o),
        .iwb_dat_i(iwb_dat_i), .iwb_ack_i(iwb_ack_i), .iwb_err_i(iwb_err_i),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size),
        .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .ls_done(ls_done), .ls_fault(ls_fault),
        .ls_cause(ls_cause), .ls_stall(ls_stall),
        .dwb_addr_o(dwb_addr_o), .dwb_dat_o(dwb_dat_o),
        .dwb_sel_o(dwb_sel_o), .dwb_we_o(dwb_we_o),
        .dwb_cyc_o(dwb_cyc_o), .dwb_stb_o(dwb_stb_o),
        .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i), .dwb_err_i(dwb_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a data request for one edge, then drop it.
    task automatic ls_issue(input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] wd);
        ls_req = 1'b1; ls_we = we; ls_size = size;
        ls_unsigned = uns; ls_addr = addr; ls_wdata = wd;
        tick();
        ls_req = 1'b0;
    endtask

    task automatic if_issue(input logic [31:0] pc);
        if_req = 1'b1; if_pc = pc;
        tick();
        if_req = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        if_req = 0; if_pc = 0; iwb_dat_i = 0; iwb_ack_i = 0; iwb_err_i = 0;
        ls_req = 0; ls_we = 0; ls_size = 0; ls_unsigned = 0;
        ls_addr = 0; ls_wdata = 0;
        dwb_dat_i = 0; dwb_ack_i = 0; dwb_err_i = 0;
        repeat (3) tick();
        chk("rst_icyc", {31'b0, iwb_cyc_o}, 0);
        chk("rst_dcyc", {31'b0, dwb_cyc_o}, 0);
        chk("rst_stall", {30'b0, if_stall, ls_stall}, 0);
        chk("rst_rdata", ls_rdata, 0);
        chk("rst_sel", {28'b0, dwb_sel_o}, 0);
        rst = 1'b1;
        tick();

        // Fetch, ack two cycles after stb rises
        if_issue(32'h100);
        chk("f_cyc", {31'b0, iwb_cyc_o & iwb_stb_o}, 1);
        chk("f_addr", iwb_addr_o, 32'h100);
        chk("f_stall", {31'b0, if_stall}, 1);
        tick();
        iwb_ack_i = 1'b1; iwb_dat_i = 32'h00500093;
        tick();
        iwb_ack_i = 1'b0;
        chk("f_valid", {31'b0, if_valid}, 1);
        chk("f_instr", if_instr, 32'h00500093);
        chk("f_cyc_off", {31'b0, iwb_cyc_o}, 0);
        tick();
        chk("f_valid_off", {31'b0, if_valid}, 0);
        chk("f_stall_off", {31'b0, if_stall}, 0);

        // Load byte signed then unsigned
        ls_issue(1'b0, 2'b00, 1'b0, 32'h203, 0);
        chk("lb_sel", {28'b0, dwb_sel_o}, 32'h8);
        chk("lb_addr", dwb_addr_o, 32'h200);
        chk("lb_we", {31'b0, dwb_we_o}, 0);
        dwb_ack_i = 1'b1; dwb_dat_i = 32'h80FF1234;
        tick();
        dwb_ack_i = 1'b0;
        chk("lb_done", {31'b0, ls_done}, 1);
        chk("lb_rdata", ls_rdata, 32'hFFFFFF80);
        tick();
        chk("lb_stall", {31'b0, ls_stall}, 0);
        ls_issue(1'b0, 2'b00, 1'b1, 32'h203, 0);
        dwb_ack_i = 1'b1;
        tick();
        dwb_ack_i = 1'b0;
        chk("lbu_done", {31'b0, ls_done}, 1);
        chk("lbu_rdata", ls_rdata, 32'h00000080);
        tick();

        // Load half signed from upper half
        ls_issue(1'b0, 2'b01, 1'b0, 32'h212, 0);
        chk("lh_sel", {28'b0, dwb_sel_o}, 32'hC);
        dwb_ack_i = 1'b1;
        tick();
        dwb_ack_i = 1'b0;
        chk("lh_rdata", ls_rdata, 32'hFFFF80FF);
        tick();

        // Store half
        ls_issue(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000BEEF);
        chk("sh_sel", {28'b0, dwb_sel_o}, 32'hC);
        chk("sh_dat", dwb_dat_o, 32'hBEEFBEEF);
        chk("sh_we", {31'b0, dwb_we_o}, 1);
        chk("sh_addr", dwb_addr_o, 32'h300);
        dwb_ack_i = 1'b1;
        tick();
        dwb_ack_i = 1'b0;
        chk("sh_done", {31'b0, ls_done}, 1);
        tick();

        // Misaligned word load
        ls_issue(1'b0, 2'b10, 1'b0, 32'h401, 0);
        chk("mis_fault", {31'b0, ls_fault}, 1);
        chk("mis_cause", {30'b0, ls_cause}, 1);
        chk("mis_cyc", {31'b0, dwb_cyc_o}, 0);
        chk("mis_stall", {31'b0, ls_stall}, 0);
        tick();
        chk("mis_fault_off", {31'b0, ls_fault}, 0);
        chk("mis_cyc2", {31'b0, dwb_cyc_o}, 0);

        // Illegal size
        ls_issue(1'b0, 2'b11, 1'b0, 32'h400, 0);
        chk("ill_cause", {30'b0, ls_cause}, 1);
        tick();

        // Fetch timeout (TIMEOUT=8), then a normal fetch
        if_issue(32'h104);
        n = 0;
        while (iwb_cyc_o && n < 20) begin
            n++;
            tick();
        end
        chk("to_cycles", n, 8);
        chk("to_fault", {31'b0, if_fault}, 1);
        chk("to_cause", {30'b0, if_cause}, 3);
        tick();
        if_issue(32'h108);
        iwb_ack_i = 1'b1; iwb_dat_i = 32'hDEADBEEF;
        tick();
        iwb_ack_i = 1'b0;
        chk("to_valid", {31'b0, if_valid}, 1);
        chk("to_instr", if_instr, 32'hDEADBEEF);
        tick();

        // ack and err together on a store word
        ls_issue(1'b1, 2'b10, 1'b0, 32'h500, 32'h12345678);
        chk("ae_sel", {28'b0, dwb_sel_o}, 32'hF);
        chk("ae_dat", dwb_dat_o, 32'h12345678);
        dwb_ack_i = 1'b1; dwb_err_i = 1'b1;
        tick();
        dwb_ack_i = 1'b0; dwb_err_i = 1'b0;
        chk("ae_fault", {31'b0, ls_fault}, 1);
        chk("ae_cause", {30'b0, ls_cause}, 2);
        chk("ae_done", {31'b0, ls_done}, 0);
        tick();

        // Misaligned fetch
        if_issue(32'h102);
        chk("fmis_cause", {30'b0, if_cause}, 1);
        chk("fmis_cyc", {31'b0, iwb_cyc_o}, 0);
        tick();

        // Reset mid-BUS
        ls_issue(1'b0, 2'b10, 1'b0, 32'h600, 0);
        chk("rb_cyc_on", {31'b0, dwb_cyc_o}, 1);
        #2 rst = 1'b0;
        #1;
        chk("rb_cyc", {31'b0, dwb_cyc_o}, 0);
        chk("rb_stb", {31'b0, dwb_stb_o}, 0);
        dwb_ack_i = 1'b1;
        tick();
        dwb_ack_i = 1'b0;
        chk("rb_pulse", {30'b0, ls_done, ls_fault}, 0);
        rst = 1'b1;
        tick();
        chk("rb_pulse2", {30'b0, ls_done, ls_fault}, 0);
        chk("rb_stall", {31'b0, ls_stall}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
